// File: rtl/isa_pkg.sv
// ISA constants shared by the encoder: opcodes, ALU ops, field positions,
// instruction classes and the per-class field-zeroing helpers.
package isa_pkg;

  localparam int INSN_W   = 32;
  localparam int REG_W    = 5;
  localparam int IMM_W    = 17;
  localparam int TARGET_W = 27;

  localparam int OPC_LSB   = 27;
  localparam int RD_LSB    = 22;
  localparam int RS_LSB    = 17;
  localparam int RT_LSB    = 12;
  localparam int SHAMT_LSB = 7;
  localparam int ALUOP_LSB = 2;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic [2:0] {CLS_R, CLS_I, CLS_JI, CLS_JII, CLS_ILL} insn_cls_e;

  // Register-bearing fields of an instruction, as kept for the round-trip check.
  typedef struct packed {
    logic [4:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
  } insn_regs_t;

  function automatic insn_cls_e insn_class(input logic [4:0] op);
    insn_cls_e cls;
    case (op)
      OP_RTYPE:                               cls = CLS_R;
      OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT: cls = CLS_I;
      OP_J, OP_JAL, OP_BEX, OP_SETX:         cls = CLS_JI;
      OP_JR:                                  cls = CLS_JII;
      default:                                cls = CLS_ILL;
    endcase
    return cls;
  endfunction

  function automatic insn_regs_t mask_regs(input insn_cls_e cls, input logic [4:0] op,
                                           input logic [4:0] rd, input logic [4:0] rs,
                                           input logic [4:0] rt);
    insn_regs_t r;
    r        = '0;
    r.opcode = op;
    case (cls)
      CLS_R:   begin r.rd = rd; r.rs = rs; r.rt = rt; end
      CLS_I:   begin r.rd = rd; r.rs = rs; end
      CLS_JII: r.rd = rd;
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO buffering encoded words; DEPTH must be a power of two >= 2.
module enc_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: storage is deliberately not reset; cnt_q alone decides which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/insn_encoder.sv
// Packs instruction fields into 32-bit ISA words and streams them with addresses
// to imem. Optional round-trip self-check enabled by INSN_ENC_ROUNDTRIP_CHECK_EN.
module insn_encoder
  import isa_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [4:0]        in_aluop,
  input  logic [16:0]       in_imm,
  input  logic [26:0]       in_target,
  input  logic              load_addr,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_insn,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_illegal,
  output logic [7:0]        illegal_cnt
`ifdef INSN_ENC_ROUNDTRIP_CHECK_EN
  ,
  output logic              chk_err
`endif
);

`ifdef INSN_ENC_ROUNDTRIP_CHECK_EN
  localparam int ENTRY_W = INSN_W + $bits(insn_regs_t);
`else
  localparam int ENTRY_W = INSN_W;
`endif

  insn_cls_e         in_cls;
  logic [INSN_W-1:0] enc_word;
  logic [ENTRY_W-1:0] push_data, head_data;
  logic              fifo_full, fifo_empty;
  logic              accept, push, pop, ill_acc;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  assign in_cls   = insn_class(in_opcode);
  assign in_ready = !fifo_full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && (in_cls != CLS_ILL);
  assign ill_acc  = accept && (in_cls == CLS_ILL);
  assign pop      = out_valid && out_ready;

  always_comb begin
    enc_word = '0;
    enc_word[OPC_LSB +: REG_W] = in_opcode;
    case (in_cls)
      CLS_R: begin
        enc_word[RD_LSB    +: REG_W] = in_rd;
        enc_word[RS_LSB    +: REG_W] = in_rs;
        enc_word[RT_LSB    +: REG_W] = in_rt;
        enc_word[SHAMT_LSB +: REG_W] = in_shamt;
        enc_word[ALUOP_LSB +: REG_W] = in_aluop;
      end
      CLS_I: begin
        enc_word[RD_LSB +: REG_W] = in_rd;
        enc_word[RS_LSB +: REG_W] = in_rs;
        enc_word[IMM_W-1:0]       = in_imm;
      end
      CLS_JI:  enc_word[TARGET_W-1:0] = in_target;
      CLS_JII: enc_word[RD_LSB +: REG_W] = in_rd;
      default: enc_word = '0;
    endcase
  end

`ifdef INSN_ENC_ROUNDTRIP_CHECK_EN
  assign push_data = {mask_regs(in_cls, in_opcode, in_rd, in_rs, in_rt), enc_word};
`else
  assign push_data = enc_word;
`endif

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (push_data),
    .pop     (pop),
    .rdata   (head_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Output is the registered head entry; words take their address only when they leave.
  assign out_valid   = !fifo_empty;
  assign out_insn    = fifo_empty ? '0 : head_data[INSN_W-1:0];
  assign out_addr    = addr_q;
  assign err_illegal = err_q;
  assign illegal_cnt = cnt_q;

  always_comb begin
    addr_d = addr_q;
    err_d  = err_q | ill_acc;
    cnt_d  = cnt_q;
    if (load_addr)  addr_d = addr_in;
    else if (pop)   addr_d = addr_q + 1'b1;
    if (ill_acc && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef INSN_ENC_ROUNDTRIP_CHECK_EN
  insn_regs_t stored_regs, decoded_regs;
  logic       chk_q, chk_d;

  assign stored_regs  = head_data[ENTRY_W-1:INSN_W];
  assign decoded_regs = mask_regs(insn_class(out_insn[OPC_LSB +: REG_W]),
                                  out_insn[OPC_LSB +: REG_W], out_insn[RD_LSB +: REG_W],
                                  out_insn[RS_LSB +: REG_W], out_insn[RT_LSB +: REG_W]);
  assign chk_d        = chk_q | (out_valid && (decoded_regs != stored_regs));
  assign chk_err      = chk_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) chk_q <= 1'b0;
    else          chk_q <= chk_d;
  end
`endif

endmodule

// File: tb/tb_insn_encoder.sv
// Directed plus randomized bench for insn_encoder against a queue-based reference model.
module tb_insn_encoder;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 2;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              in_valid, in_ready;
  logic [4:0]        in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop;
  logic [16:0]       in_imm;
  logic [26:0]       in_target;
  logic              load_addr;
  logic [ADDR_W-1:0] addr_in;
  logic              out_valid, out_ready;
  logic [31:0]       out_insn;
  logic [ADDR_W-1:0] out_addr;
  logic              err_illegal;
  logic [7:0]        illegal_cnt;
`ifdef INSN_ENC_ROUNDTRIP_CHECK_EN
  logic              chk_err;
`endif

  insn_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_rd       (in_rd),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_shamt    (in_shamt),
    .in_aluop    (in_aluop),
    .in_imm      (in_imm),
    .in_target   (in_target),
    .load_addr   (load_addr),
    .addr_in     (addr_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_insn    (out_insn),
    .out_addr    (out_addr),
    .err_illegal (err_illegal),
    .illegal_cnt (illegal_cnt)
`ifdef INSN_ENC_ROUNDTRIP_CHECK_EN
    ,
    .chk_err     (chk_err)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: pending words in order, pop-time address counter, illegal tracking.
  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] m_addr;
  logic              m_err;
  int                m_cnt;

  logic [4:0] legal_ops [11] = '{5'd0, 5'd5, 5'd7, 5'd8, 5'd2, 5'd6, 5'd1, 5'd3, 5'd22, 5'd21, 5'd4};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [4:0] op);
    return op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd21, 5'd22};
  endfunction

  function automatic logic [31:0] ref_word();
    longint w;
    w = longint'(in_opcode) * (2 ** 27);
    if (in_opcode == 5'd0)
      w += longint'(in_rd) * (2 ** 22) + longint'(in_rs) * (2 ** 17) + longint'(in_rt) * (2 ** 12)
         + longint'(in_shamt) * (2 ** 7) + longint'(in_aluop) * 4;
    else if (in_opcode inside {5'd5, 5'd7, 5'd8, 5'd2, 5'd6})
      w += longint'(in_rd) * (2 ** 22) + longint'(in_rs) * (2 ** 17) + longint'(in_imm);
    else if (in_opcode inside {5'd1, 5'd3, 5'd22, 5'd21})
      w += longint'(in_target);
    else if (in_opcode == 5'd4)
      w += longint'(in_rd) * (2 ** 22);
    return w[31:0];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_addr = '0;
    m_err  = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic compare_outputs();
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check("out_insn", out_insn, exp_q[0]);
      check("out_addr", 32'(out_addr), 32'(m_addr));
    end
    check("err_illegal", 32'(err_illegal), 32'(m_err));
    check("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
`ifdef INSN_ENC_ROUNDTRIP_CHECK_EN
    check("chk_err", 32'(chk_err), 32'd0);
`endif
  endtask

  // One clock: predict from the inputs currently driven, advance, compare.
  task automatic step();
    bit          acc, pop, legal, ld;
    logic [31:0] word;
    logic [ADDR_W-1:0] ld_val;
    check("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
    acc    = in_valid && (exp_q.size() < DEPTH);
    pop    = out_ready && (exp_q.size() > 0);
    legal  = is_legal(in_opcode);
    word   = ref_word();
    ld     = load_addr;
    ld_val = addr_in;
    @(posedge clock);
    #1;
    if (pop) void'(exp_q.pop_front());
    if (ld) m_addr = ld_val;
    else if (pop) m_addr = m_addr + 1'b1;
    if (acc) begin
      if (legal) exp_q.push_back(word);
      else begin
        m_err = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    compare_outputs();
  endtask

  task automatic set_bundle(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] alu,
                            input logic [16:0] imm, input logic [26:0] tgt);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rd     = rd;
    in_rs     = rs;
    in_rt     = rt;
    in_shamt  = sh;
    in_aluop  = alu;
    in_imm    = imm;
    in_target = tgt;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_insn"}, out_insn, 32'd0);
    check({tag, "_addr"}, 32'(out_addr), 32'd0);
    check({tag, "_err"}, 32'(err_illegal), 32'd0);
    check({tag, "_cnt"}, 32'(illegal_cnt), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    load_addr = 1'b0;
    addr_in   = '0;
    set_bundle(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0);
    in_valid  = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Load start address, then addi / add / mult streamed back-to-back.
    load_addr = 1'b1;
    addr_in   = 12'h010;
    step();
    load_addr = 1'b0;
    out_ready = 1'b1;
    set_bundle(5'd5, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0);
    step();
    check("addi_word", out_insn, 32'h28440005);
    check("addi_addr", 32'(out_addr), 32'h010);
    set_bundle(5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 17'd0, 27'd0);
    step();
    check("add_word", out_insn, 32'h00C22000);
    check("add_addr", 32'(out_addr), 32'h011);
    set_bundle(5'd0, 5'd4, 5'd5, 5'd6, 5'd0, 5'b00110, 17'd0, 27'd0);
    step();
    check("mult_word", out_insn, 32'h010A6018);
    check("mult_addr", 32'(out_addr), 32'h012);

    // J-class words must zero the unused register/immediate fields.
    set_bundle(5'd3, 5'd7, 5'd9, 5'd11, 5'd2, 5'd3, 17'h1ABCD, 27'h100);
    step();
    check("jal_word", out_insn, 32'h18000100);
    set_bundle(5'd4, 5'd31, 5'd17, 5'd9, 5'd3, 5'd5, 17'h1234, 27'h5555);
    step();
    check("jr_word", out_insn, 32'h27C00000);
    in_valid = 1'b0;
    step();

    // Back-pressure: two accepts fill the buffer, head holds, then drain in order.
    out_ready = 1'b0;
    set_bundle(5'd5, 5'd8, 5'd9, 5'd0, 5'd0, 5'd0, 17'h00ABC, 27'd0);
    step();
    held = out_insn;
    set_bundle(5'd7, 5'd10, 5'd11, 5'd0, 5'd0, 5'd0, 17'h1F000, 27'd0);
    step();
    check("hold_ready_low", 32'(in_ready), 32'd0);
    set_bundle(5'd8, 5'd12, 5'd13, 5'd0, 5'd0, 5'd0, 17'h00042, 27'd0);
    step();
    step();
    check("hold_insn_stable", out_insn, held);
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Illegal opcodes: accepted, never buffered, counter saturates.
    set_bundle(5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 17'd1, 27'd1);
    step();
    check("ill_err", 32'(err_illegal), 32'd1);
    check("ill_cnt1", 32'(illegal_cnt), 32'd1);
    check("ill_no_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 300; i++) step();
    check("ill_cnt_sat", 32'(illegal_cnt), 32'd255);
    in_valid = 1'b0;

    // Address wrap at the top of imem.
    load_addr = 1'b1;
    addr_in   = 12'hFFF;
    step();
    load_addr = 1'b0;
    set_bundle(5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'h1FFFF, 27'd0);
    step();
    check("wrap_word", out_insn, 32'h2801FFFF);
    check("wrap_addr", 32'(out_addr), 32'hFFF);
    set_bundle(5'd5, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0, 17'd1, 27'd0);
    step();
    check("wrap_next_addr", 32'(out_addr), 32'h000);
    in_valid = 1'b0;
    step();

    // Randomized traffic, including illegal opcodes and load_addr collisions.
    for (int i = 0; i < 800; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_opcode = ($urandom_range(0, 7) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 10)];
      in_rd     = 5'($urandom);
      in_rs     = 5'($urandom);
      in_rt     = 5'($urandom);
      in_shamt  = 5'($urandom);
      in_aluop  = 5'($urandom);
      in_imm    = 17'($urandom);
      in_target = 27'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      load_addr = ($urandom_range(0, 15) == 0);
      addr_in   = ADDR_W'($urandom);
      step();
    end
    load_addr = 1'b0;

    // Mid-stream asynchronous reset clears everything without waiting for a clock.
    out_ready = 1'b0;
    set_bundle(5'd5, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 17'd7, 27'd0);
    step();
    step();
    set_bundle(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midreset");
    in_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    set_bundle(5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h7FFFFFF);
    step();
    check("post_reset_word", out_insn, 32'h0FFFFFFF);
    check("post_reset_addr", 32'(out_addr), 32'h000);
    in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
